iob_uart2iob: RTL and testbench
===============================

// Module: iob_uart2iob
// PURPOSE
//  Serial-to-bus bridge: the initiator end of the IOb native interface, controlled from a host over RS232.
//  It receives command frames on rxd_i (8N1) and issues one IOb native transaction per frame (write or read).
//  It then returns an acknowledge byte or the read data on txd_o.
//  Sits between the board UART pins and the system interconnect (debug/boot loader access to any IOb peripheral).
// PARAMETERS
//  DATA_W   32   bus data width; only 32 supported (4 data bytes per frame)
//  ADDR_W   32   bus address width; 4 address bytes always received, upper bits above ADDR_W discarded
//  BIT_DIV  868  clock cycles per serial bit (100 MHz / 115200); must be >= 16
// PORTS
//  clk_i        in   1         system clock
//  arst_n_i     in   1         reset, asynchronous, active-low
//  rxd_i        in   1         serial receive line, idle high
//  txd_o        out  1         serial transmit line, idle high
//  cts_i        in   1         host ready to receive; a TX byte starts only while high
//  rts_o        out  1         bridge ready to receive a byte from host
//  iob_valid_o  out  1         IOb request valid
//  iob_addr_o   out  ADDR_W    IOb byte address
//  iob_wdata_o  out  DATA_W    IOb write data
//  iob_wstrb_o  out  DATA_W/8  IOb write strobe; 0 = read
//  iob_ready_i  in   1         IOb request accepted
//  iob_rvalid_i in   1         IOb read data valid
//  iob_rdata_i  in   DATA_W    IOb read data
//  busy_o       out  1         high whenever FSM is not in S_CMD
// BEHAVIOUR
//  Reset (arst_n_i low, any time incl. mid-frame/mid-transaction): FSM->S_CMD, counters and shift regs cleared,
//   txd_o=1, rts_o=0 while in reset then 1 in S_CMD, iob_valid_o=0, iob_addr_o=0, iob_wdata_o=0, iob_wstrb_o=0, busy_o=0.
//  Frame (all multi-byte fields LSB byte first): write = 0x57,A0..A3,D0..D3 -> reply 0x06 (ACK);
//   read = 0x52,A0..A3 -> reply D0..D3; any other command byte -> reply 0x15 (NAK), back to S_CMD.
//  RX: rxd_i double-flop synchronised; falling edge starts bit timer; start bit re-sampled at BIT_DIV/2,
//   high there = false start, ignored. Data bits sampled at BIT_DIV/2 + k*BIT_DIV, LSB first.
//   Stop bit sampled low = framing error: frame discarded, NAK sent, FSM -> S_CMD.
//  rts_o=1 only in S_CMD/S_ADDR/S_DATA; bytes arriving in other states are ignored (not buffered).
//  TX: 10 bit times/byte (start, 8 data LSB first, stop); txd_o registered. Next byte waits for cts_i=1,
//   sampled only at byte boundaries; cts_i dropping mid-byte does not abort the byte.
//  FSM: S_CMD -(0x57/0x52)-> S_ADDR -(4th byte, write)-> S_DATA -(4th byte)-> S_REQ
//       S_ADDR -(4th byte, read)-> S_REQ; S_REQ -(ready, write)-> S_TX(ACK); S_REQ -(ready, read)-> S_RWAIT
//       S_RWAIT -(rvalid)-> S_TX(4 bytes); S_TX -(last stop bit done)-> S_CMD; bad cmd/framing -> S_TX(NAK).
//  Bus: iob_valid_o asserted the cycle after entering S_REQ, held with stable addr/wdata/wstrb until
//   the cycle iob_ready_i=1 (accept), deasserted next cycle. Write: wstrb=4'hF. Read: wstrb=0.
//   iob_rdata_i captured on the cycle iob_rvalid_i=1 in S_RWAIT (earliest: cycle after accept);
//   rvalid outside S_RWAIT ignored. No bus timeout: bridge waits indefinitely for ready/rvalid.
//  Address: byte address as received, no alignment check; bytes beyond ADDR_W dropped.
//  Bit counter wraps 0..BIT_DIV-1; byte counter 0..3, cleared on every FSM state change.
// TESTING
//  1 write 57 00 01 00 00 EF BE AD DE, ready after 3 cyc -> valid: addr=0x100 wdata=0xDEADBEEF wstrb=F; txd 0x06
//  2 read 52 04 00 00 00, ready=1 immediately, rvalid 5 cyc later, rdata=0x12345678 -> wstrb=0; txd 78 56 34 12
//  3 cmd 0x41 -> no bus activity, txd 0x15, rts_o back to 1; then test 1 passes unchanged
//  4 stop bit forced low on 2nd addr byte -> NAK, valid never asserted; 50-cycle low glitch on rxd ignored
//  5 cts_i=0 during read reply -> txd idle high until cts_i=1, then all 4 bytes complete
//  6 arst_n_i pulsed in S_RWAIT / mid TX byte -> valid=0, txd=1, S_CMD; next full write frame correct

Source files
------------

// File: rtl/iob_uart2iob.sv
// iob_uart2iob: RS232 command frames (8N1) to IOb native bus transactions, replying ACK/NAK or read data.
module iob_uart2iob #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int BIT_DIV = 868
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                rxd_i,
  output logic                txd_o,
  input  logic                cts_i,
  output logic                rts_o,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  output logic                busy_o
);
  localparam int CW = $clog2(BIT_DIV);
  localparam logic [CW-1:0] C_MAX  = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] C_HALF = CW'(BIT_DIV / 2 - 1);

  typedef enum logic [2:0] {S_CMD, S_ADDR, S_DATA, S_REQ, S_RWAIT, S_TX} state_t;
  state_t r_state, w_nxt;

  logic [1:0]        r_rx_s;
  logic              r_rx_d, r_rx_act, r_rx_vld, r_rx_ferr;
  logic [CW-1:0]     r_rx_cnt;
  logic [3:0]        r_rx_bit;
  logic [7:0]        r_rx_sh, r_rx_byte;
  logic              r_tx_act, r_txd;
  logic [CW-1:0]     r_tx_cnt;
  logic [3:0]        r_tx_bit;
  logic [8:0]        r_tx_sh;
  logic [DATA_W-1:0] r_tx_data;
  logic [1:0]        r_tx_last, r_byte;
  logic              r_we, r_valid;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic w_rx, w_cmd_ok, w_acc, w_tx_done, w_tx_load;

  assign w_rx      = r_rx_s[1];
  assign w_cmd_ok  = r_rx_byte == 8'h57 || r_rx_byte == 8'h52;
  assign w_acc     = r_valid && iob_ready_i;
  assign w_tx_done = r_tx_act && r_tx_cnt == C_MAX && r_tx_bit == 4'd9;
  assign w_tx_load = r_state == S_TX && !r_tx_act && cts_i;

  // Receiver: mid-bit sampling, false start rejected, stop bit reported as framing status
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      r_rx_s    <= 2'b11;
      r_rx_d    <= 1'b1;
      r_rx_act  <= 1'b0;
      r_rx_vld  <= 1'b0;
      r_rx_ferr <= 1'b0;
      r_rx_cnt  <= '0;
      r_rx_bit  <= '0;
      r_rx_sh   <= '0;
      r_rx_byte <= '0;
    end else begin
      r_rx_s   <= {r_rx_s[0], rxd_i};
      r_rx_d   <= w_rx;
      r_rx_vld <= 1'b0;
      if (!r_rx_act) begin
        if (r_rx_d && !w_rx) begin
          r_rx_act <= 1'b1;
          r_rx_cnt <= '0;
          r_rx_bit <= '0;
        end
      end else begin
        r_rx_cnt <= r_rx_cnt == C_MAX ? '0 : r_rx_cnt + 1'b1;
        if (r_rx_cnt == C_HALF) begin
          r_rx_bit <= r_rx_bit + 4'd1;
          if (r_rx_bit == 4'd0 && w_rx) r_rx_act <= 1'b0;
          else if (r_rx_bit == 4'd9) begin
            r_rx_act  <= 1'b0;
            r_rx_vld  <= 1'b1;
            r_rx_ferr <= !w_rx;
            r_rx_byte <= r_rx_sh;
          end else if (r_rx_bit != 4'd0) r_rx_sh <= {w_rx, r_rx_sh[7:1]};
        end
      end
    end

  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) r_state <= S_CMD;
    else r_state <= w_nxt;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_CMD:   if (r_rx_vld) w_nxt = (!r_rx_ferr && w_cmd_ok) ? S_ADDR : S_TX;
      S_ADDR:  if (r_rx_vld) w_nxt = r_rx_ferr ? S_TX : r_byte != 2'd3 ? S_ADDR : r_we ? S_DATA : S_REQ;
      S_DATA:  if (r_rx_vld) w_nxt = r_rx_ferr ? S_TX : r_byte == 2'd3 ? S_REQ : S_DATA;
      S_REQ:   if (w_acc) w_nxt = r_we ? S_TX : S_RWAIT;
      S_RWAIT: if (iob_rvalid_i) w_nxt = S_TX;
      S_TX:    if (w_tx_done && r_byte == r_tx_last) w_nxt = S_CMD;
      default: w_nxt = S_CMD;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      r_byte    <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_valid   <= 1'b0;
      r_tx_data <= '0;
      r_tx_last <= '0;
    end else begin
      r_byte <= w_nxt != r_state ? 2'd0 :
                ((r_rx_vld && (r_state == S_ADDR || r_state == S_DATA)) || w_tx_done) ? r_byte + 2'd1 : r_byte;
      if (r_state == S_CMD && r_rx_vld) r_we <= r_rx_byte == 8'h57;
      if (r_state == S_ADDR && r_rx_vld) r_addr <= {r_rx_byte, r_addr[31:8]};
      if (r_state == S_DATA && r_rx_vld) r_wdata <= {r_rx_byte, r_wdata[DATA_W-1:8]};
      r_valid <= r_state == S_REQ && !w_acc;
      if (w_nxt == S_REQ && r_state != S_REQ) r_wstrb <= {(DATA_W/8){r_we}};
      // Reply chosen by the state we leave: read data, ACK after a write, NAK otherwise
      if (w_nxt == S_TX && r_state != S_TX) begin
        r_tx_data <= r_state == S_RWAIT ? iob_rdata_i : r_state == S_REQ ? DATA_W'(8'h06) : DATA_W'(8'h15);
        r_tx_last <= r_state == S_RWAIT ? 2'd3 : 2'd0;
      end
    end

  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      r_tx_act <= 1'b0;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '1;
      r_txd    <= 1'b1;
    end else if (w_tx_load) begin
      r_tx_act <= 1'b1;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_txd    <= 1'b0;
      r_tx_sh  <= {1'b1, r_tx_data[{r_byte, 3'b000} +: 8]};
    end else if (r_tx_act) begin
      r_tx_cnt <= r_tx_cnt == C_MAX ? '0 : r_tx_cnt + 1'b1;
      if (r_tx_cnt == C_MAX) begin
        r_tx_bit <= r_tx_bit + 4'd1;
        if (r_tx_bit == 4'd9) r_tx_act <= 1'b0;
        else begin
          r_txd   <= r_tx_sh[0];
          r_tx_sh <= {1'b1, r_tx_sh[8:1]};
        end
      end
    end

  assign txd_o       = r_txd;
  assign rts_o       = arst_n_i && (r_state == S_CMD || r_state == S_ADDR || r_state == S_DATA);
  assign busy_o      = r_state != S_CMD;
  assign iob_valid_o = r_valid;
  assign iob_addr_o  = r_addr[ADDR_W-1:0];
  assign iob_wdata_o = r_wdata;
  assign iob_wstrb_o = r_wstrb;
endmodule

// File: tb/tb_iob_uart2iob.sv
// tb_iob_uart2iob: directed frames on rxd; bus and txd scoreboards check the bridge's responses.
module tb_iob_uart2iob;
  localparam int BD = 112;
  logic clk = 0, arst_n_i = 0, rxd_i = 1, cts_i = 1, iob_ready_i = 0, iob_rvalid_i = 0;
  logic [31:0] iob_rdata_i = 0;
  logic txd_o, rts_o, iob_valid_o, busy_o;
  logic [31:0] iob_addr_o, iob_wdata_o;
  logic [3:0] iob_wstrb_o;
  int errs = 0, checks = 0, rst_cnt = 0, acc_cnt = 0;
  int rdy_dly = 0, rv_dly = 1;
  logic [31:0] rd_val = 0;
  logic [7:0] exp_tx[$];
  logic [67:0] exp_bus[$];

  iob_uart2iob #(.DATA_W(32), .ADDR_W(32), .BIT_DIV(BD)) dut (
    .clk_i(clk), .arst_n_i(arst_n_i), .rxd_i(rxd_i), .txd_o(txd_o), .cts_i(cts_i), .rts_o(rts_o),
    .iob_valid_o(iob_valid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
    .iob_wstrb_o(iob_wstrb_o), .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
    .iob_rdata_i(iob_rdata_i), .busy_o(busy_o));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bound_chk(input string nm, input logic ok);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: timed out waiting for DUT", nm);
    end
  endtask

  // Bus slave model
  initial begin
    logic rd;
    forever begin
      @(negedge clk);
      if (iob_valid_o) begin
        rd = iob_wstrb_o == 4'h0;
        repeat (rdy_dly) @(negedge clk);
        iob_ready_i = 1;
        @(negedge clk);
        iob_ready_i = 0;
        if (rd) begin
          repeat (rv_dly - 1) @(negedge clk);
          iob_rdata_i = rd_val;
          iob_rvalid_i = 1;
          @(negedge clk);
          iob_rvalid_i = 0;
        end
      end
    end
  end

  // Bus monitor
  initial begin
    logic [67:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (iob_valid_o && iob_ready_i) begin
        acc_cnt++;
        if (exp_bus.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL bus_unexpected: got addr=%0h wstrb=%0h expected no transaction", iob_addr_o, iob_wstrb_o);
        end else begin
          e = exp_bus.pop_front();
          chk("bus_addr", 64'(iob_addr_o), 64'(e[67:36]));
          chk("bus_wstrb", 64'(iob_wstrb_o), 64'(e[3:0]));
          if (e[3:0] != 4'h0) chk("bus_wdata", 64'(iob_wdata_o), 64'(e[35:4]));
        end
      end
    end
  end

  // txd monitor; bytes cut by a reset are discarded
  initial begin
    logic [7:0] b;
    logic stp;
    int rc;
    forever begin
      @(negedge clk);
      if (txd_o === 1'b0) begin
        rc = rst_cnt;
        repeat (BD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = txd_o;
        end
        repeat (BD) @(negedge clk);
        stp = txd_o;
        if (rc == rst_cnt) begin
          if (exp_tx.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL tx_unexpected: got byte %0h expected none", b);
          end else begin
            chk("tx_byte", 64'(b), 64'(exp_tx.pop_front()));
            chk("tx_stop", 64'(stp), 64'd1);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic bad);
    rxd_i = 0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_i = b[i];
      repeat (BD) @(negedge clk);
    end
    rxd_i = ~bad;
    repeat (BD) @(negedge clk);
    rxd_i = 1;
    if (bad) repeat (BD) @(negedge clk);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57, 0);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 0);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 0);
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h52, 0);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 0);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_bus.size() != 0 || busy_o) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    bound_chk(nm, n < 30000);
    repeat (BD) @(negedge clk);
  endtask

  task automatic wait_txd_low(input string nm);
    int n = 0;
    while (txd_o !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    bound_chk(nm, n < 20000);
  endtask

  task automatic count_low(input string nm, input int cyc);
    int lows = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (txd_o !== 1'b1) lows++;
    end
    chk(nm, 64'(lows), 64'd0);
  endtask

  task automatic pulse_rst(input string nm);
    rst_cnt++;
    arst_n_i = 0;
    #1;
    chk({nm, "_valid"}, 64'(iob_valid_o), 64'd0);
    chk({nm, "_txd"}, 64'(txd_o), 64'd1);
    chk({nm, "_busy"}, 64'(busy_o), 64'd0);
    chk({nm, "_rts"}, 64'(rts_o), 64'd0);
    repeat (3) @(negedge clk);
    arst_n_i = 1;
    @(negedge clk);
    chk({nm, "_rts_after"}, 64'(rts_o), 64'd1);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a0, n;
    repeat (3) @(negedge clk);
    chk("rst_txd", 64'(txd_o), 64'd1);
    chk("rst_rts", 64'(rts_o), 64'd0);
    chk("rst_valid", 64'(iob_valid_o), 64'd0);
    chk("rst_addr", 64'(iob_addr_o), 64'd0);
    chk("rst_wdata", 64'(iob_wdata_o), 64'd0);
    chk("rst_wstrb", 64'(iob_wstrb_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    arst_n_i = 1;
    repeat (2) @(negedge clk);
    chk("idle_rts", 64'(rts_o), 64'd1);

    // 1: write
    rdy_dly = 3;
    exp_bus.push_back({32'h0000_0100, 32'hDEAD_BEEF, 4'hF});
    exp_tx.push_back(8'h06);
    send_write(32'h0000_0100, 32'hDEAD_BEEF);
    drain("t1");

    // 2: read
    rdy_dly = 0; rv_dly = 5; rd_val = 32'h1234_5678;
    exp_bus.push_back({32'h0000_0004, 32'h0, 4'h0});
    exp_tx.push_back(8'h78); exp_tx.push_back(8'h56); exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
    send_read(32'h0000_0004);
    drain("t2");

    // 3: bad command, then write again
    exp_tx.push_back(8'h15);
    send_byte(8'h41, 0);
    drain("t3_nak");
    chk("t3_rts", 64'(rts_o), 64'd1);
    rdy_dly = 3;
    exp_bus.push_back({32'h0000_0100, 32'hDEAD_BEEF, 4'hF});
    exp_tx.push_back(8'h06);
    send_write(32'h0000_0100, 32'hDEAD_BEEF);
    drain("t3_wr");

    // 4: framing error on 2nd address byte, then a short glitch
    exp_tx.push_back(8'h15);
    send_byte(8'h57, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 1);
    drain("t4_nak");
    rxd_i = 0;
    repeat (50) @(negedge clk);
    rxd_i = 1;
    repeat (2 * BD) @(negedge clk);
    chk("t4_glitch_busy", 64'(busy_o), 64'd0);
    repeat (10 * BD) @(negedge clk);

    // 5: flow control on the read reply
    cts_i = 0; rdy_dly = 1; rv_dly = 2; rd_val = 32'hA5C3_0F96;
    exp_bus.push_back({32'h0000_0020, 32'h0, 4'h0});
    exp_tx.push_back(8'h96); exp_tx.push_back(8'h0F); exp_tx.push_back(8'hC3); exp_tx.push_back(8'hA5);
    send_read(32'h0000_0020);
    count_low("t5_cts_hold", 1000);
    chk("t5_busy", 64'(busy_o), 64'd1);
    cts_i = 1;
    wait_txd_low("t5_first_byte");
    repeat (3 * BD) @(negedge clk);
    cts_i = 0;
    repeat (8 * BD) @(negedge clk);
    count_low("t5_cts_hold2", 500);
    cts_i = 1;
    drain("t5");

    // 6: reset in S_RWAIT, reset mid TX byte, then a clean write
    rdy_dly = 0; rv_dly = 400; rd_val = 32'hFFFF_FFFF;
    exp_bus.push_back({32'h0000_0008, 32'h0, 4'h0});
    a0 = acc_cnt;
    send_read(32'h0000_0008);
    n = 0;
    while (acc_cnt == a0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    bound_chk("t6_accept", n < 5000);
    repeat (20) @(negedge clk);
    chk("t6_rwait_busy", 64'(busy_o), 64'd1);
    pulse_rst("t6_rst1");
    repeat (500) @(negedge clk);
    chk("t6_after_rvalid_busy", 64'(busy_o), 64'd0);
    send_byte(8'h00, 0);
    wait_txd_low("t6_nak_start");
    repeat (4 * BD) @(negedge clk);
    pulse_rst("t6_rst2");
    repeat (8 * BD) @(negedge clk);
    chk("t6_idle_txd", 64'(txd_o), 64'd1);
    rdy_dly = 2;
    exp_bus.push_back({32'h0000_0ABC, 32'h0123_4567, 4'hF});
    exp_tx.push_back(8'h06);
    send_write(32'h0000_0ABC, 32'h0123_4567);
    drain("t6_wr");

    chk("tx_queue_left", 64'(exp_tx.size()), 64'd0);
    chk("bus_queue_left", 64'(exp_bus.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
